// File: rtl/buffer_narrow_to_wide_if.sv
// Handshake bundle for the narrow-to-wide buffer: beat input side, word output side,
// synchronous clear and occupancy status.
interface buffer_narrow_to_wide_if #(
  parameter int IN_W  = 64,
  parameter int RATIO = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic                  clr;
  logic [IN_W-1:0]       in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [IN_W*RATIO-1:0] out_data;
  logic [RATIO-1:0]      out_keep;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         level;
  logic                  empty;
  logic                  full;

  modport slave (
    input  clr, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid, level, empty, full
  );

  modport master (
    output clr, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid, level, empty, full
  );
endinterface

// File: rtl/buffer_narrow_to_wide.sv
// Packs IN_W-bit beats into IN_W*RATIO-bit words (in_last closes a partial word)
// and queues them in a DEPTH-entry first-word-fall-through FIFO.
module buffer_narrow_to_wide #(
  parameter int IN_W  = 64,
  parameter int RATIO = 8,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(RATIO),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  buffer_narrow_to_wide_if.slave   bus
);
  localparam int WW = IN_W * RATIO;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LW-1:0]    r_lane_idx;
  logic [WW-1:0]    r_asm;
  logic [RATIO-1:0] r_keep;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_level;

  logic [WW-1:0]    r_mem_data [DEPTH];
  logic [RATIO-1:0] r_mem_keep [DEPTH];
  logic [DEPTH-1:0] r_mem_last;

  logic             w_empty;
  logic             w_full;
  logic             w_acc;
  logic             w_commit;
  logic             w_pop;
  logic [WW-1:0]    w_word;
  logic [RATIO-1:0] w_word_keep;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_empty  = (r_level == '0);
    w_full   = (r_level == CW'(DEPTH));
    w_acc    = bus.in_valid & ~w_full;
    w_commit = w_acc & ((r_lane_idx == LW'(RATIO - 1)) | bus.in_last);
    w_pop    = ~w_empty & bus.out_ready;
  end

  // Lanes above r_lane_idx are still zero because the assembly clears on every commit.
  always_comb begin
    w_word = r_asm;
    w_word[r_lane_idx*IN_W +: IN_W] = bus.in_data;
    w_word_keep = r_keep | (RATIO'(1) << r_lane_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_idx <= '0;
      r_asm      <= '0;
      r_keep     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
    end else if (bus.clr) begin
      r_lane_idx <= '0;
      r_asm      <= '0;
      r_keep     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
    end else begin
      if (w_acc) begin
        if (w_commit) begin
          r_lane_idx <= '0;
          r_asm      <= '0;
          r_keep     <= '0;
          r_wr_ptr   <= ptr_inc(r_wr_ptr);
        end else begin
          r_lane_idx <= r_lane_idx + 1'b1;
          r_asm      <= w_word;
          r_keep     <= w_word_keep;
        end
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_commit, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once level covers it.
  always_ff @(posedge clk) begin
    if (w_commit && !bus.clr) begin
      r_mem_data[r_wr_ptr] <= w_word;
      r_mem_keep[r_wr_ptr] <= w_word_keep;
      r_mem_last[r_wr_ptr] <= bus.in_last;
    end
  end

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign bus.out_keep  = w_empty ? '0 : r_mem_keep[r_rd_ptr];
  assign bus.out_last  = w_empty ? 1'b0 : r_mem_last[r_rd_ptr];
  assign bus.level     = r_level;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
endmodule
